ring_slot_scheduler: RTL and testbench
======================================

# ring_slot_scheduler

Ring-token scheduler that shares one downstream resource among N requesters using a one-hot rotating token, the same structure as the team's ring counter. The token steps one position per cycle while idle. When the token lands on an active requester, that requester gets a bounded-length grant. The block sits between the requesting engines and the shared resource and is the only source of `gnt`.

## Interface
- `N`, 4: number of requesters; token and request/grant width (N ≥ 2).
- `MAX_HOLD`, 8: maximum number of consecutive cycles one grant may last (MAX_HOLD ≥ 1).

- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `en`  input  1  scheduler enable; when 0, no new grants are issued and the token is frozen.
- `req`  input  N  per-requester request level; held high while the requester wants the resource.
- `done`  input  N  per-requester release strobe; only the bit of the current owner is looked at.
- `ring`  output  N  one-hot token position.
- `gnt`  output  N  one-hot grant; all zeros when nothing is granted.
- `gnt_valid`  output  1  equals |gnt.
- `timeout`  output  1  one-cycle pulse when a grant is revoked because MAX_HOLD was reached.

## Operation
- All outputs are registered.
- Reset values, applied while `rst` = 0:
  - `ring` = 0…01
  - `gnt` = 0, `gnt_valid` = 0, `timeout` = 0
  - state = IDLE, hold counter = 0
- Hold counter width is $clog2(MAX_HOLD+1). It never wraps and saturates at MAX_HOLD.
- Token rotates left: bit i moves to bit i+1, and the MSB wraps to bit 0.
- IDLE state:
  - If `en`=1 and (`req` & `ring`) ≠ 0, go to GRANT. Set `gnt` = `ring` and hold = 1. The token does not move.
  - Else if `en`=1, rotate `ring` by one.
  - Else (`en`=0), hold everything.
- GRANT state (owner = `gnt`):
  - The grant is released on the edge where any of these holds:
    - `done` & `gnt` ≠ 0
    - `req` & `gnt` = 0
    - hold = MAX_HOLD
  - On release: `gnt` = 0, rotate `ring` by one (fairness), hold = 0, go to IDLE.
  - Otherwise, increment hold.
- `timeout` = 1 for the cycle after a release caused only by hold = MAX_HOLD. If `done` is high or `req` is low on that same edge, the release counts as normal and `timeout` stays 0.
- `en` going to 0 during GRANT does not revoke the grant. Release rules still apply, then the block waits in IDLE with the token frozen.
- Reset asserted mid-grant: `gnt` drops to 0 immediately, without waiting for a clock edge.
- Requests on non-token positions are ignored until the token reaches them.

## Timing
- Grant latency: if `req`[k] is high while `ring`[k] is high in IDLE, `gnt`[k] rises on the next edge.
- Worst-case wait from IDLE: N−1 rotations plus 1 edge, with `en`=1.
- Maximum tenure: `gnt` is high for at most MAX_HOLD consecutive cycles.
- Release timing: `done` sampled high at edge t gives `gnt` = 0 and the rotated `ring` after edge t.
  - The new position is granted no earlier than edge t+1 (one IDLE cycle between grants).
  - Back-to-back grants to the same requester are impossible.
- `timeout` is high in exactly the same cycle that `gnt` first reads 0.
- Reset deassertion: the first rotation happens on the first edge with `rst`=1 and `en`=1.

## Test plan
- **Reset.** Hold `rst`=0 for 2 edges, then release with `req`=0 and `en`=1.
  - `ring` must read 0001 → 0010 → 0100 → 1000 → 0001 on successive edges.
  - `gnt` must stay 0000 throughout.
- **Single requester.** After reset, set `req`=0100 and `en`=1.
  - `ring` reaches 0100 after 2 edges.
  - `gnt`=0100 and `gnt_valid`=1 after the 3rd edge.
  - Pulse `done`=0100 two cycles later: `gnt`=0000 and `ring`=1000 after that edge.
- **Fair rotation.** Hold `req`=1111; each owner pulses `done` on its 2nd grant cycle.
  - Grant order must be 0001, 0010, 0100, 1000, 0001.
  - Each grant lasts 2 cycles, with 1 idle cycle between grants.
- **Timeout.** `req`=0010 held, `done` never asserted, MAX_HOLD=8.
  - `gnt`=0010 for exactly 8 cycles.
  - `timeout`=1 for one cycle as `gnt` falls, and `ring`=0100 in that cycle.
- **Simultaneous release and timeout.** Same setup as the timeout test, but `done`=0010 on the 8th grant cycle.
  - `gnt` drops as before.
  - `timeout` must stay 0.
- **Enable and async reset.**
  - `en`=0 in IDLE with `req`=1111: `ring` must stay frozen and no grant is issued.
  - Mid-grant, drive `rst`=0 between clock edges: `gnt` must read 0000 immediately, and `ring` must read 0001.

Source files
------------

// File: rtl/ring_slot_scheduler.sv
// Ring-token scheduler: a one-hot token rotates while idle and grants a bounded
// tenure to the requester it lands on, then moves on so every position gets a turn.
module ring_slot_scheduler #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] req,
  input  logic [N-1:0] done,
  output logic [N-1:0] ring,
  output logic [N-1:0] gnt,
  output logic         gnt_valid,
  output logic         timeout
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
  localparam logic [HW-1:0] HOLD_ZERO = HW'(0);
  localparam logic [N-1:0]  RING_INIT = N'(1);
  localparam logic [N-1:0]  NONE      = N'(0);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic [HW-1:0] hold_r;
  logic [HW-1:0] hold_nxt_s;
  logic [N-1:0]  ring_nxt_s;
  logic [N-1:0]  gnt_nxt_s;
  logic [N-1:0]  ring_rot_s;
  logic          timeout_nxt_s;
  logic          hit_s;
  logic          owner_done_s;
  logic          owner_gone_s;
  logic          hold_full_s;
  logic          release_s;

  assign ring_rot_s   = {ring[N-2:0], ring[N-1]};
  assign hit_s        = |(req & ring);
  assign owner_done_s = |(done & gnt);
  assign owner_gone_s = ~|(req & gnt);
  assign hold_full_s  = (hold_r == HOLD_MAX);
  assign release_s    = (state_r == GRANT) && (owner_done_s || owner_gone_s || hold_full_s);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (en && hit_s) begin
          state_nxt_s = GRANT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GRANT: begin
        if (release_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = GRANT;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Next values for token, grant, hold counter and timeout pulse
  always_comb begin
    ring_nxt_s    = ring;
    gnt_nxt_s     = gnt;
    hold_nxt_s    = hold_r;
    timeout_nxt_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (en && hit_s) begin
          gnt_nxt_s  = ring;
          hold_nxt_s = HOLD_ONE;
        end else if (en) begin
          ring_nxt_s = ring_rot_s;
        end else begin
          ring_nxt_s = ring;
        end
      end
      GRANT: begin
        if (release_s) begin
          gnt_nxt_s  = NONE;
          ring_nxt_s = ring_rot_s;
          hold_nxt_s = HOLD_ZERO;
          // A release the owner asked for (or walked away from) is not a timeout.
          timeout_nxt_s = hold_full_s && !owner_done_s && !owner_gone_s;
        end else if (!hold_full_s) begin
          hold_nxt_s = hold_r + HOLD_ONE;
        end else begin
          hold_nxt_s = hold_r;
        end
      end
      default: begin
        gnt_nxt_s  = NONE;
        hold_nxt_s = HOLD_ZERO;
      end
    endcase
  end

  // Registered token, grant and status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ring      <= RING_INIT;
      gnt       <= NONE;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
      hold_r    <= HOLD_ZERO;
    end else begin
      ring      <= ring_nxt_s;
      gnt       <= gnt_nxt_s;
      gnt_valid <= |gnt_nxt_s;
      timeout   <= timeout_nxt_s;
      hold_r    <= hold_nxt_s;
    end
  end

endmodule

// File: tb/tb_ring_slot_scheduler.sv
// Directed, table-driven bench for ring_slot_scheduler (N=4, MAX_HOLD=8) with a
// hand-written sequence for asynchronous reset in the middle of a grant.
module tb_ring_slot_scheduler;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] ring;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic       timeout;

  int n_checks;
  int n_fails;

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] exp_ring;
    logic [3:0] exp_gnt;
    logic       exp_timeout;
  } vec_t;

  vec_t vecs[$];

  ring_slot_scheduler #(.N(4), .MAX_HOLD(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .done      (done),
    .ring      (ring),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic e, input logic [3:0] rq, input logic [3:0] dn,
                     input logic [3:0] xr, input logic [3:0] xg, input logic xt);
    vec_t v;
    v.rst = r; v.en = e; v.req = rq; v.done = dn;
    v.exp_ring = xr; v.exp_gnt = xg; v.exp_timeout = xt;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; req = 4'b0000; done = 4'b0000;
    n_checks = 0; n_fails = 0;

    // Reset, then free rotation with no requests
    add(1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b0);
    add(1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b0);
    add(1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 1'b0);
    add(1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 1'b0);
    add(1'b1, 1'b1, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 1'b0);
    add(1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b0);
    // Single requester on position 2
    add(1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b0);
    add(1'b1, 1'b1, 4'b0100, 4'b0000, 4'b0010, 4'b0000, 1'b0);
    add(1'b1, 1'b1, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 1'b0);
    add(1'b1, 1'b1, 4'b0100, 4'b0000, 4'b0100, 4'b0100, 1'b0);
    add(1'b1, 1'b1, 4'b0100, 4'b0000, 4'b0100, 4'b0100, 1'b0);
    add(1'b1, 1'b1, 4'b0100, 4'b0100, 4'b1000, 4'b0000, 1'b0);
    add(1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b0);
    // Fair rotation: all request, each owner releases in its 2nd grant cycle
    for (int k = 0; k < 5; k++) begin
      logic [3:0] pos;
      logic [3:0] nxt;
      pos = 4'b0001 << (k % 4);
      nxt = 4'b0001 << ((k + 1) % 4);
      add(1'b1, 1'b1, 4'b1111, 4'b0000, pos, pos, 1'b0);
      add(1'b1, 1'b1, 4'b1111, 4'b0000, pos, pos, 1'b0);
      add(1'b1, 1'b1, 4'b1111, pos,     nxt, 4'b0000, 1'b0);
    end
    // Timeout: req on position 1 never releases
    for (int k = 0; k < 8; k++) add(1'b1, 1'b1, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 1'b0);
    add(1'b1, 1'b1, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 1'b1);
    add(1'b1, 1'b1, 4'b0010, 4'b0000, 4'b1000, 4'b0000, 1'b0);
    add(1'b1, 1'b1, 4'b0010, 4'b0000, 4'b0001, 4'b0000, 1'b0);
    add(1'b1, 1'b1, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 1'b0);
    // Simultaneous done and hold limit: release without timeout
    for (int k = 0; k < 8; k++) add(1'b1, 1'b1, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 1'b0);
    add(1'b1, 1'b1, 4'b0010, 4'b0010, 4'b0100, 4'b0000, 1'b0);
    // Enable low in IDLE freezes the token and blocks grants
    for (int k = 0; k < 3; k++) add(1'b1, 1'b0, 4'b1111, 4'b0000, 4'b0100, 4'b0000, 1'b0);
    add(1'b1, 1'b1, 4'b1111, 4'b0000, 4'b0100, 4'b0100, 1'b0);
    // Enable dropping mid-grant keeps the grant, then the token stays frozen
    add(1'b1, 1'b0, 4'b1111, 4'b0000, 4'b0100, 4'b0100, 1'b0);
    add(1'b1, 1'b0, 4'b1111, 4'b0100, 4'b1000, 4'b0000, 1'b0);
    add(1'b1, 1'b0, 4'b1111, 4'b0000, 4'b1000, 4'b0000, 1'b0);
    add(1'b1, 1'b0, 4'b1111, 4'b0000, 4'b1000, 4'b0000, 1'b0);
    add(1'b1, 1'b1, 4'b1111, 4'b0000, 4'b1000, 4'b1000, 1'b0);

    #1;
    foreach (vecs[i]) begin
      rst  = vecs[i].rst;
      en   = vecs[i].en;
      req  = vecs[i].req;
      done = vecs[i].done;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d ring", i), ring, vecs[i].exp_ring);
      check($sformatf("vec%0d gnt", i), gnt, vecs[i].exp_gnt);
      check($sformatf("vec%0d gnt_valid", i), {3'b000, gnt_valid}, {3'b000, |vecs[i].exp_gnt});
      check($sformatf("vec%0d timeout", i), {3'b000, timeout}, {3'b000, vecs[i].exp_timeout});
    end

    // Asynchronous reset between edges while position 3 holds the grant
    #2;
    rst = 1'b0;
    #1;
    check("async_rst gnt", gnt, 4'b0000);
    check("async_rst ring", ring, 4'b0001);
    check("async_rst gnt_valid", {3'b000, gnt_valid}, 4'b0000);
    check("async_rst timeout", {3'b000, timeout}, 4'b0000);

    // First enabled edge after release rotates the token
    @(negedge clk);
    rst = 1'b1; en = 1'b1; req = 4'b0000; done = 4'b0000;
    @(posedge clk);
    #1;
    check("post_rst ring", ring, 4'b0010);
    check("post_rst gnt", gnt, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
